// File: rtl/addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe_if
// Description : Operand/result bundle for addsub_pipe. Carries the upstream
//               valid/ready handshake with operands x, y, op, sat_en and the
//               downstream valid/ready handshake with res, carry, ovf, zero
//               and the completed-operation counter op_count.
//               slave  : the add/sub pipeline side.
//               master : the producer/consumer side that drives operands and
//                        out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, x, y, op, sat_en, out_ready,
        output in_ready, out_valid, res, carry, ovf, zero, op_count
    );

    modport master (
        output in_valid, x, y, op, sat_en, out_ready,
        input  in_ready, out_valid, res, carry, ovf, zero, op_count
    );
endinterface
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pipe
// Description : Two-stage pipelined adder/subtractor with optional signed
//               saturation, carry/overflow/zero flags and a counter of
//               results accepted downstream.
//               Ports: clk  - rising-edge clock
//                      rst  - synchronous active-high reset
//                      bus  - addsub_pipe_if.slave (operand handshake in,
//                             result handshake out, op_count)
//               Stage 1 registers the operands; the arithmetic sits between
//               stage 1 and stage 2; stage 2 registers result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    addsub_pipe_if.slave bus
);

    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: captured operands
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_y;
    logic             r_s1_op;
    logic             r_s1_sat;

    // Stage 2: result and flags
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic [CNT_W-1:0] r_op_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_y_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    // A stage may load whenever it is empty or its contents move on, so a
    // full pipe with out_ready held high streams one operation per cycle.
    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Subtract is x + ~y + 1: invert y and feed op in as the carry-in.
    assign w_y_eff = r_s1_op ? ~r_s1_y : r_s1_y;
    assign w_sum   = {1'b0, r_s1_x} + {1'b0, w_y_eff} + {{WIDTH{1'b0}}, r_s1_op};

    // Overflow: both effective operand signs agree but the sum sign differs.
    assign w_ovf = (r_s1_x[WIDTH-1] == w_y_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_s1_x[WIDTH-1]);

    // On overflow the true result has the sign of x, so clamp toward it.
    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        if (r_s1_sat && w_ovf) begin
            w_res = r_s1_x[WIDTH-1] ? c_sat_min : c_sat_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_op    <= 1'b0;
            r_s1_sat   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_x     <= bus.x;
            r_s1_y     <= bus.y;
            r_s1_op    <= bus.op;
            r_s1_sat   <= bus.sat_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_res      <= w_res;
            r_carry    <= w_sum[WIDTH];
            r_ovf      <= w_ovf;
            r_zero     <= (w_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_s2_valid && bus.out_ready) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.res       = r_res;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_pipe
// Description : Self-checking bench for addsub_pipe (WIDTH=32, CNT_W=4).
//               Directed vector table, backpressure, throughput/counter wrap,
//               reset mid-flight and randomized traffic against a reference
//               model built from plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             zero;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             op;
        logic             sat;
        res_t             exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    res_t exp_q[$];
    logic [CNT_W-1:0] mdl_cnt;

    addsub_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed/unsigned integer arithmetic in 64 bits.
    function automatic res_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sub, input logic sat);
        res_t r;
        longint sa;
        longint sb;
        longint exact;
        longint unsigned ua;
        longint unsigned ub;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'b0, a};
        ub    = {32'b0, b};
        exact = sub ? (sa - sb) : (sa + sb);
        r.carry = sub ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
        r.ovf   = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        if (sat && r.ovf) r.res = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else              r.res = exact[31:0];
        r.zero = (r.res == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_cnt = '0;
        end else begin
            check("op_count_track", 64'(bus.op_count), 64'(mdl_cnt));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'd1, 64'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_result", 64'({bus.res, bus.carry, bus.ovf, bus.zero}), 64'(e));
                end
                mdl_cnt = mdl_cnt + 1'b1;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.x, bus.y, bus.op, bus.sat_en));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic o, input logic s);
        bus.x        = a;
        bus.y        = b;
        bus.op       = o;
        bus.sat_en   = s;
        bus.in_valid = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.out_valid) break;
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'd1, 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        total = 0;
        bad   = 0;
        mdl_cnt = '0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.op        = 1'b0;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{32'd5, 32'd3, 1'b1, 1'b0, '{32'd2, 1'b1, 1'b0, 1'b0}};
        vecs[1] = '{32'd3, 32'd5, 1'b1, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{32'd7, 32'd7, 1'b1, 1'b0, '{32'd0, 1'b1, 1'b0, 1'b1}};
        vecs[3] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{32'h8000_0000, 32'd1, 1'b1, 1'b1, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'd0, 1'b1, 1'b0, 1'b1}};
        vecs[7] = '{32'd0, 32'h8000_0000, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_res_flags", 64'({bus.res, bus.carry, bus.ovf, bus.zero}), 64'd0);
        check("rst_op_count", 64'(bus.op_count), 64'd0);

        // Backpressure: two accepted, then stalled with stable output
        begin
            res_t ea;
            ea = ref_model(32'd100, 32'd1, 1'b0, 1'b0);
            tick();
            bus.out_ready = 1'b0;
            drive(32'd100, 32'd1, 1'b0, 1'b0);
            @(negedge clk);
            check("bp_acc0", 64'(bus.in_ready), 64'd1);
            tick();
            drive(32'd200, 32'd50, 1'b1, 1'b0);
            @(negedge clk);
            check("bp_acc1", 64'(bus.in_ready), 64'd1);
            tick();
            drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                check("bp_hold_data", 64'({bus.res, bus.carry, bus.ovf, bus.zero}), 64'(ea));
                tick();
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            check("bp_release_ready", 64'(bus.in_ready), 64'd1);
            tick();
            drive(32'd9, 32'd12, 1'b1, 1'b1);
            @(negedge clk);
            check("bp_flow_ready", 64'(bus.in_ready), 64'd1);
            tick();
            drain();
            check("bp_op_count", 64'(bus.op_count), 64'd4);
        end

        // Directed vector table, each checked for exact 2-cycle latency
        for (int v = 0; v < 8; v++) begin
            int lat;
            tick();
            bus.out_ready = 1'b1;
            drive(vecs[v].x, vecs[v].y, vecs[v].op, vecs[v].sat);
            tick();
            bus.in_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    lat = n;
                    break;
                end
            end
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'd2);
            check($sformatf("vec%0d_result", v),
                  64'({bus.res, bus.carry, bus.ovf, bus.zero}), 64'(vecs[v].exp));
            drain();
        end

        // Full throughput and counter wrap: 17 back-to-back operations
        begin
            int bubbles;
            int ov_bad;
            bubbles = 0;
            ov_bad  = 0;
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            bus.out_ready = 1'b1;
            drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 21; k++) begin
                @(negedge clk);
                if (k < 17 && !bus.in_ready) bubbles++;
                if (bus.out_valid != (k >= 2 && k <= 18)) ov_bad++;
                tick();
                if (k + 1 < 17)
                    drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("tp_in_bubbles", 64'(bubbles), 64'd0);
            check("tp_out_pattern", 64'(ov_bad), 64'd0);
            check("tp_op_count_wrap", 64'(bus.op_count), 64'd1);
        end

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            tick();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.x         = pick();
            bus.y         = pick();
            bus.op        = 1'($urandom_range(0, 1));
            bus.sat_en    = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        drain();

        // Reset with both stages full
        begin
            int seen;
            tick();
            bus.out_ready = 1'b0;
            drive(32'd1, 32'd2, 1'b0, 1'b0);
            tick();
            drive(32'd3, 32'd4, 1'b1, 1'b0);
            tick();
            bus.in_valid = 1'b0;
            @(negedge clk);
            check("mf_full_valid", 64'(bus.out_valid), 64'd1);
            check("mf_full_ready", 64'(bus.in_ready), 64'd0);
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge clk);
            check("mf_out_valid", 64'(bus.out_valid), 64'd0);
            check("mf_op_count", 64'(bus.op_count), 64'd0);
            check("mf_in_ready", 64'(bus.in_ready), 64'd1);
            bus.out_ready = 1'b1;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mf_no_stale", 64'(seen), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port x, input, WIDTH bits: the minuend or first addend.
REQ-008 The block SHALL have port y, input, WIDTH bits: the subtrahend or second addend.
REQ-009 The block SHALL have port op, input, 1 bit: 0 = add (x+y), 1 = subtract (x-y).
REQ-010 The block SHALL have port sat_en, input, 1 bit: 1 = two's-complement signed saturation of the result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port res, output, WIDTH bits: the result.
REQ-014 The block SHALL have port carry, output, 1 bit: the unsigned carry-out; for subtract, 1 = no borrow (x >= y unsigned).
REQ-015 The block SHALL have port ovf, output, 1 bit: signed overflow of the unsaturated result.
REQ-016 The block SHALL have port zero, output, 1 bit: res (after saturation) equals 0.
REQ-017 The block SHALL have port op_count, output, CNT_W bits: the number of results accepted downstream.

Function
REQ-018 The block SHALL implement subtraction as x + ~y + 1 and addition as x + y + 0, computed at WIDTH+1 bits; carry SHALL be bit WIDTH of that sum.
REQ-019 ovf SHALL be 1 when the operand sign bits (x and ~y for subtract, x and y for add) are equal and differ from the result sign bit.
REQ-020 With sat_en=1 and ovf=1, res SHALL be the most positive value (0x7F..F) if the x sign bit is 0, and the most negative value (0x80..0) otherwise; with sat_en=0 the wrapped sum SHALL be output, and ovf SHALL be reported in both cases.
REQ-021 The pipeline SHALL have two register stages: S1 captures x, y, op and sat_en; S2 captures res and the flags. Latency from input handshake to out_valid SHALL be exactly 2 cycles when out_ready=1.
REQ-022 An input handshake SHALL occur when in_valid && in_ready; an output handshake SHALL occur when out_valid && out_ready.
REQ-023 S2 SHALL advance when !S2_valid || out_ready; S1 SHALL advance when !S1_valid || S2 advances; in_ready SHALL equal the S1 advance condition, combinationally.
REQ-024 A stalled stage (out_ready=0 with the stage full) SHALL hold its data and flags unchanged; out_valid SHALL NOT deassert until the output handshake occurs.
REQ-025 With in_valid=1 and out_ready=1 held, throughput SHALL be one operation per cycle with no bubbles.
REQ-026 A stage that advances with no valid data upstream SHALL become empty (valid=0); data registers of empty stages are don't-care.
REQ-027 op_count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 Results SHALL leave the block in acceptance order; no operation SHALL be dropped or duplicated.

Reset
REQ-029 While rst=1 at a clock edge, S1_valid, S2_valid, out_valid and op_count SHALL clear to 0, and res, carry, ovf and zero SHALL clear to 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations with no output handshake and no op_count change.

Verification
REQ-032 Subtract, no borrow (WIDTH=32): x=5, y=3, op=1, sat_en=0 -> 2 cycles later res=2, carry=1, ovf=0, zero=0.
REQ-033 Subtract with borrow: x=3, y=5, op=1 -> res=0xFFFFFFFE, carry=0, ovf=0; then x=7, y=7, op=1 -> res=0, zero=1, carry=1.
REQ-034 Overflow and saturation: add 0x7FFFFFFF+1 with sat_en=0 -> res=0x80000000, ovf=1; the same add with sat_en=1 -> res=0x7FFFFFFF, ovf=1; subtract 0x80000000-1 with sat_en=1 -> res=0x80000000, ovf=1.
REQ-035 Backpressure: stream 4 operations, hold out_ready=0 for 5 cycles -> in_ready falls after 2 accepted, outputs are held stable, and after release all 4 results emerge in order, op_count=4.
REQ-036 Full throughput and wrap: with CNT_W=4, 17 back-to-back operations with out_ready=1 -> one result per cycle, op_count=1 after the last.
REQ-037 Reset mid-flight: assert rst with both stages full -> next cycle out_valid=0, op_count=0, in_ready=1, and no stale result appears.
